// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: write-side arbiter for the two framebuffer banks.
// Bank A holds columns 0-31 and bank B holds columns 32-63; the word address
// is the image row. Coprocessor word writes share the write ports with a
// clear/fill engine that sweeps every row of both banks at once.
//
// Build option: define FB_VBLANK_SYNC_EN to hold off new writes and pause the
// clear sweep while active_video is high. Without it, active_video is ignored.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting; a pending clear wins over a coprocessor write
// WRITE | one coprocessor word is on a write port and wr_ack is high
// CLEAR | both banks are being filled row by row, then one clear_done cycle
module fb_write_ctrl #(
    parameter int ROWS  = 64,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active_video,
    input  logic             wr_req,
    input  logic             wr_bank,
    input  logic [5:0]       wr_row,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             clear_req,
    input  logic             clear_val,
    output logic             clear_done,
    output logic             busy,
    output logic [5:0]       wraddressA,
    output logic [5:0]       wraddressB,
    output logic [WIDTH-1:0] dataA,
    output logic [WIDTH-1:0] dataB,
    output logic             wrenA,
    output logic             wrenB
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    // rowCnt holds the next row to present; reaching ROWS ends the sweep.
    localparam logic [6:0] ROW_END = 7'(ROWS);

    state_t           state, stateNext;
    logic [6:0]       rowCnt, rowCntNext;
    logic             clearPend, clearPendNext;
    logic             clearValQ, clearValNext;
    logic             gateOpen;
    logic             wrenANext, wrenBNext, ackNext, doneNext, busyNext;
    logic [5:0]       addrANext, addrBNext;
    logic [WIDTH-1:0] dataANext, dataBNext;

`ifdef FB_VBLANK_SYNC_EN
    assign gateOpen = ~active_video;
`else
    logic unusedVideo;
    assign unusedVideo = active_video;
    assign gateOpen    = 1'b1;
`endif

    // Next state and next registered outputs; outputs hold unless rewritten.
    always_comb begin
        stateNext     = state;
        rowCntNext    = rowCnt;
        clearPendNext = clearPend;
        clearValNext  = clearValQ;
        wrenANext     = 1'b0;
        wrenBNext     = 1'b0;
        ackNext       = 1'b0;
        doneNext      = 1'b0;
        addrANext     = wraddressA;
        addrBNext     = wraddressB;
        dataANext     = dataA;
        dataBNext     = dataB;

        // Folding a same-cycle clear_req in here is what lets a clear beat a
        // simultaneous write request.
        if (clear_req && state != CLEAR) begin
            clearPendNext = 1'b1;
            clearValNext  = clear_val;
        end

        case (state)
            IDLE: begin
                if (gateOpen) begin
                    if (clearPendNext) begin
                        stateNext     = CLEAR;
                        clearPendNext = 1'b0;
                        wrenANext     = 1'b1;
                        wrenBNext     = 1'b1;
                        addrANext     = 6'd0;
                        addrBNext     = 6'd0;
                        dataANext     = {WIDTH{clearValNext}};
                        dataBNext     = {WIDTH{clearValNext}};
                        rowCntNext    = 7'd1;
                    end else if (wr_req) begin
                        stateNext = WRITE;
                        ackNext   = 1'b1;
                        if (wr_bank) begin
                            wrenBNext = 1'b1;
                            addrBNext = wr_row;
                            dataBNext = wr_data;
                        end else begin
                            wrenANext = 1'b1;
                            addrANext = wr_row;
                            dataANext = wr_data;
                        end
                    end
                end
            end
            WRITE: begin
                stateNext = IDLE;
            end
            CLEAR: begin
                if (clear_done) begin
                    stateNext  = IDLE;
                    rowCntNext = 7'd0;
                end else if (rowCnt == ROW_END) begin
                    doneNext = 1'b1;
                end else if (gateOpen) begin
                    wrenANext  = 1'b1;
                    wrenBNext  = 1'b1;
                    addrANext  = rowCnt[5:0];
                    addrBNext  = rowCnt[5:0];
                    dataANext  = {WIDTH{clearValQ}};
                    dataBNext  = {WIDTH{clearValQ}};
                    rowCntNext = rowCnt + 7'd1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = (stateNext != IDLE) || clearPendNext;
    end

    // State, sweep counter and all output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rowCnt     <= 7'd0;
            clearPend  <= 1'b0;
            clearValQ  <= 1'b0;
            wrenA      <= 1'b0;
            wrenB      <= 1'b0;
            wr_ack     <= 1'b0;
            clear_done <= 1'b0;
            busy       <= 1'b0;
            wraddressA <= 6'd0;
            wraddressB <= 6'd0;
            dataA      <= '0;
            dataB      <= '0;
        end else begin
            state      <= stateNext;
            rowCnt     <= rowCntNext;
            clearPend  <= clearPendNext;
            clearValQ  <= clearValNext;
            wrenA      <= wrenANext;
            wrenB      <= wrenBNext;
            wr_ack     <= ackNext;
            clear_done <= doneNext;
            busy       <= busyNext;
            wraddressA <= addrANext;
            wraddressB <= addrBNext;
            dataA      <= dataANext;
            dataB      <= dataBNext;
        end
    end

endmodule

// File: doc/fb_write_ctrl.md
# fb_write_ctrl

Write-side controller for the two 64-word x 32-bit framebuffer memories scanned by the pixel renderer. Bank A holds image columns 0-31, bank B columns 32-63; word address = image row 0-63; bit 31-k of a word is column k within its half. Arbitrates between a coprocessor word-write requester and an internal clear/fill engine. Drives both memories' write ports, leaving the read ports to the display path.

## Interface
Parameters:
- ROWS, 64, rows swept by a clear; address width fixed at 6.
- WIDTH, 32, memory word width.

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst  in  1  reset, asynchronous, active-low
- active_video  in  1  high while the display is scanning visible pixels
- wr_req  in  1  coprocessor write request, held until acknowledged
- wr_bank  in  1  0 = bank A, 1 = bank B
- wr_row  in  6  target word address
- wr_data  in  32  word to write
- wr_ack  out  1  one-cycle pulse: request committed
- clear_req  in  1  one-cycle pulse: fill whole framebuffer
- clear_val  in  1  fill value, sampled with clear_req
- clear_done  out  1  one-cycle pulse after last clear row written
- busy  out  1  high while state != IDLE or a clear is pending
- wraddressA, wraddressB  out  6  write addresses
- dataA, dataB  out  32  write data
- wrenA, wrenB  out  1  write enables

## Operation
- States: IDLE, WRITE, CLEAR.
- clear_req in any state except CLEAR sets clear_pend and latches clear_val. clear_req during CLEAR is ignored.
- IDLE, gate open (see Configuration):
  - If clear_pend: go to CLEAR, row_cnt=0, clear clear_pend.
  - Else if wr_req: register bank, row and data, and go to WRITE.
  - Clear has priority over a simultaneous write.
- WRITE (1 cycle):
  - Assert wrenA (bank 0) or wrenB (bank 1), with wraddress = row and data = word.
  - Assert wr_ack in the same cycle, then return to IDLE.
- CLEAR:
  - Each enabled cycle: wrenA = wrenB = 1, both addresses = row_cnt, data = {32{clear_val}}, then row_cnt increments.
  - After row 63: clear_done pulses the following cycle and the state returns to IDLE.
  - Pending wr_req waits, with no ack.
- Outputs are registered. When not writing, wren=0 and address/data hold their last values.
- A requester must not change wr_bank, wr_row or wr_data while wr_req is high and wr_ack has not been seen.
- Reset (async, any time, including mid-clear): state IDLE, clear_pend=0, row_cnt=0, all wren/ack/done/busy=0, addresses=0, data=0. An aborted clear is not resumed.

## Timing
- wr_req sampled high in IDLE at edge N: wrenX and wr_ack are high during cycle N+1. Maximum throughput is one write per 2 cycles.
- A clear accepted at edge N writes rows 0..63 in cycles N+1..N+64 when ungated. clear_done is high in cycle N+65.
- busy rises the cycle after acceptance or after clear_req, and falls with return to IDLE and no clear pending.

## Configuration
- FB_VBLANK_SYNC_EN defined:
  - IDLE accepts nothing while active_video=1.
  - In CLEAR, cycles with active_video=1 hold row_cnt with wren=0, and the sweep resumes when active_video=0.
  - A WRITE already issued completes.
- FB_VBLANK_SYNC_EN undefined: active_video is ignored and the gate is always open.

## Test plan
- Reset mid-clear (row_cnt=20, rst low one cycle): all outputs 0, state IDLE, no clear_done ever.
- wr_req, bank=1, row=5, data=32'hA5A5_0F0F, active_video=0: one cycle later wrenB=1, wraddressB=5, dataB=A5A50F0F, wr_ack=1, wrenA=0.
- clear_req with clear_val=1, ungated: 64 consecutive cycles with wrenA=wrenB=1, addresses 0..63, data FFFFFFFF; clear_done one cycle later; busy spans the whole sweep.
- clear_req and wr_req in the same cycle: the clear runs first. wr_ack arrives 2 cycles after clear_done, with the write's data intact.
- clear_req during CLEAR: ignored, with exactly 64 row writes and one clear_done.
- With FB_VBLANK_SYNC_EN, active_video toggles 10 cycles high / 10 low during a clear: no wren while high, rows contiguous with no skips or repeats, and the write held off until active_video=0.
